// File: rtl/router_ni_inject.sv
// Network-interface injection stage: two per-VC flit FIFOs feeding the router
// local input port, with a packet-aware selector that keeps wormhole packets
// contiguous and round-robins between VCs at packet boundaries.
module router_ni_inject #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        RST_,
    input  logic [34:0] IN_DATA,
    input  logic        IN_VALID,
    input  logic        IN_VCH,
    output logic [1:0]  IN_RDY,
    output logic [34:0] ODATA,
    output logic        OVALID,
    output logic        OVCH,
    input  logic [1:0]  IRDY,
    output logic        OVF,
    output logic [15:0] FLIT_CNT
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

    logic [34:0]   mem_q    [2][DEPTH];
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [CW-1:0] count_q  [2];

    logic [1:0]  not_empty;
    logic [1:0]  push;
    logic [1:0]  pop;
    logic        sel;
    logic        xfer;
    logic [34:0] head_flit;

    state_e state_q;
    logic   lock_vc_q;
    logic   sel_q;
    logic   last_q;
    // Previous cycle offered a flit the router did not take; sel must not move.
    logic   hold_q;

    // Occupancy flags; a same-cycle pop never raises IN_RDY.
    always_comb begin
        for (int v = 0; v < 2; v++) begin
            not_empty[v] = (count_q[v] != '0);
            IN_RDY[v]    = (count_q[v] < CW'(DEPTH));
        end
    end

    // VC selection: lock wins, then a pending offer, then round-robin.
    always_comb begin
        sel = sel_q;
        if (state_q == StLocked) begin
            sel = lock_vc_q;
        end else if (hold_q) begin
            sel = sel_q;
        end else if (not_empty == 2'b11) begin
            sel = ~last_q;
        end else if (not_empty[0]) begin
            sel = 1'b0;
        end else if (not_empty[1]) begin
            sel = 1'b1;
        end
    end

    // Output port view of the selected FIFO head and push/pop strobes.
    always_comb begin
        head_flit = mem_q[sel][rd_ptr_q[sel]];
        OVALID    = not_empty[sel];
        OVCH      = sel;
        ODATA     = OVALID ? head_flit : '0;
        xfer      = OVALID && IRDY[sel];
        for (int v = 0; v < 2; v++) begin
            push[v] = IN_VALID && (IN_VCH == 1'(v)) && IN_RDY[v];
            pop[v]  = xfer && (sel == 1'(v));
        end
    end

    // FIFO storage; contents need no reset since ODATA is masked when empty.
    always_ff @(posedge clk) begin
        for (int v = 0; v < 2; v++) begin
            if (push[v]) begin
                mem_q[v][wr_ptr_q[v]] <= IN_DATA;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) begin
            for (int v = 0; v < 2; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
            end
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (push[v]) begin
                    wr_ptr_q[v] <= wr_ptr_q[v] + PW'(1);
                end
                if (pop[v]) begin
                    rd_ptr_q[v] <= rd_ptr_q[v] + PW'(1);
                end
                count_q[v] <= count_q[v] + CW'(push[v]) - CW'(pop[v]);
            end
        end
    end

    // Packet lock FSM: head-only flit locks, tail unlocks and records the grant.
    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) begin
            state_q   <= StUnlocked;
            lock_vc_q <= 1'b0;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            hold_q    <= 1'b0;
        end else begin
            sel_q  <= sel;
            hold_q <= OVALID && !xfer;
            if (xfer) begin
                unique case (state_q)
                    StUnlocked: begin
                        if (head_flit[34] && !head_flit[33]) begin
                            state_q   <= StLocked;
                            lock_vc_q <= sel;
                        end else if (head_flit[33]) begin
                            last_q <= sel;
                        end
                    end
                    StLocked: begin
                        if (head_flit[33]) begin
                            state_q <= StUnlocked;
                            last_q  <= lock_vc_q;
                        end
                    end
                    default: state_q <= StUnlocked;
                endcase
            end
        end
    end

    // Sticky overflow flag and delivered-flit counter.
    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) begin
            OVF      <= 1'b0;
            FLIT_CNT <= '0;
        end else begin
            if (IN_VALID && !IN_RDY[IN_VCH]) begin
                OVF <= 1'b1;
            end
            if (xfer) begin
                FLIT_CNT <= FLIT_CNT + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_router_ni_inject.sv
// Testbench for router_ni_inject: directed scenarios plus randomized traffic
// checked against a queue-based packet-level reference model.
module tb_router_ni_inject;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        RST_;
    logic [34:0] IN_DATA;
    logic        IN_VALID;
    logic        IN_VCH;
    logic [1:0]  IN_RDY;
    logic [34:0] ODATA;
    logic        OVALID;
    logic        OVCH;
    logic [1:0]  IRDY;
    logic        OVF;
    logic [15:0] FLIT_CNT;

    int tests = 0;
    int fails = 0;

    router_ni_inject #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .RST_     (RST_),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_VCH   (IN_VCH),
        .IN_RDY   (IN_RDY),
        .ODATA    (ODATA),
        .OVALID   (OVALID),
        .OVCH     (OVCH),
        .IRDY     (IRDY),
        .OVF      (OVF),
        .FLIT_CNT (FLIT_CNT)
    );

    always #5 clk = ~clk;

    // Reference model state: per-VC queues and packet-level arbitration state.
    logic [34:0] mq0[$];
    logic [34:0] mq1[$];
    logic        m_locked, m_lockvc, m_last, m_sel, m_pending, m_ovf;
    logic [15:0] m_cnt;

    logic        e_valid, e_vch;
    logic [34:0] e_data;
    logic [1:0]  e_rdy;

    // Flits observed leaving the DUT.
    logic [34:0] got[$];

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        m_locked  = 1'b0;
        m_lockvc  = 1'b0;
        m_last    = 1'b1;
        m_sel     = 1'b0;
        m_pending = 1'b0;
        m_ovf     = 1'b0;
        m_cnt     = 16'd0;
    endtask

    task automatic model_expect();
        logic n0, n1;
        n0 = (mq0.size() != 0);
        n1 = (mq1.size() != 0);
        e_rdy[0] = (mq0.size() < DEPTH);
        e_rdy[1] = (mq1.size() < DEPTH);
        if (m_locked)      e_vch = m_lockvc;
        else if (m_pending) e_vch = m_sel;
        else if (n0 && n1) e_vch = ~m_last;
        else if (n0)       e_vch = 1'b0;
        else if (n1)       e_vch = 1'b1;
        else               e_vch = m_sel;
        e_valid = e_vch ? n1 : n0;
        e_data  = e_valid ? (e_vch ? mq1[0] : mq0[0]) : 35'd0;
    endtask

    // One clock cycle of stimulus; entered and left at a falling edge.
    task automatic cycle(input logic v, input logic vch, input logic [34:0] d,
                         input logic [1:0] irdy);
        logic xfer, acc;
        IN_VALID = v;
        IN_VCH   = vch;
        IN_DATA  = d;
        IRDY     = irdy;
        #1;
        if (OVALID && IRDY[OVCH]) got.push_back(ODATA);
        model_expect();
        xfer = e_valid && irdy[e_vch];
        acc  = v && e_rdy[vch];
        if (v && !acc) m_ovf = 1'b1;
        if (xfer) begin
            if (e_vch) mq1.delete(0);
            else       mq0.delete(0);
            m_cnt = m_cnt + 16'd1;
            if (!m_locked) begin
                if (e_data[34] && !e_data[33]) begin
                    m_locked = 1'b1;
                    m_lockvc = e_vch;
                end else if (e_data[33]) begin
                    m_last = e_vch;
                end
            end else if (e_data[33]) begin
                m_locked = 1'b0;
                m_last   = m_lockvc;
            end
        end
        if (acc) begin
            if (vch) mq1.push_back(d);
            else     mq0.push_back(d);
        end
        m_pending = e_valid && !xfer;
        m_sel     = e_vch;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        RST_     = 1'b0;
        IN_VALID = 1'b0;
        IN_VCH   = 1'b0;
        IN_DATA  = '0;
        IRDY     = 2'b00;
        @(negedge clk);
        @(negedge clk);
        RST_ = 1'b1;
        model_reset();
        got.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (IN_RDY !== 2'b11) begin fails++; $display("FAIL reset_in_rdy got=%b want=11", IN_RDY); end
        tests++; if (OVALID !== 1'b0) begin fails++; $display("FAIL reset_ovalid got=%b want=0", OVALID); end
        tests++; if (ODATA !== 35'd0) begin fails++; $display("FAIL reset_odata got=%h want=0", ODATA); end
        tests++; if (OVCH !== 1'b0) begin fails++; $display("FAIL reset_ovch got=%b want=0", OVCH); end
        tests++; if (OVF !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b want=0", OVF); end
        tests++; if (FLIT_CNT !== 16'd0) begin fails++; $display("FAIL reset_cnt got=%h want=0", FLIT_CNT); end
    endtask

    task automatic test_single();
        do_reset();
        cycle(1'b1, 1'b1, 35'h6_0000_0001, 2'b11);
        tests++; if (OVALID !== 1'b1) begin fails++; $display("FAIL single_ovalid got=%b want=1", OVALID); end
        tests++; if (OVCH !== 1'b1) begin fails++; $display("FAIL single_ovch got=%b want=1", OVCH); end
        tests++; if (ODATA !== 35'h6_0000_0001) begin fails++; $display("FAIL single_odata got=%h want=600000001", ODATA); end
        cycle(1'b0, 1'b0, 35'd0, 2'b11);
        tests++; if (FLIT_CNT !== 16'd1) begin fails++; $display("FAIL single_cnt got=%h want=1", FLIT_CNT); end
        tests++; if (OVALID !== 1'b0) begin fails++; $display("FAIL single_empty got=%b want=0", OVALID); end
        // Unlocked after a single-flit packet: a VC0 flit flows immediately.
        cycle(1'b1, 1'b0, 35'h6_0000_0002, 2'b11);
        tests++; if (OVALID !== 1'b1 || OVCH !== 1'b0) begin
            fails++; $display("FAIL single_unlocked got=%b/%b want=1/0", OVALID, OVCH);
        end
    endtask

    task automatic test_order();
        logic [34:0] want [4];
        want[0] = 35'h4_0000_00A0;
        want[1] = 35'h0_0000_00A1;
        want[2] = 35'h2_0000_00A2;
        want[3] = 35'h6_0000_00B0;
        do_reset();
        cycle(1'b1, 1'b0, want[0], 2'b00);
        cycle(1'b1, 1'b1, want[3], 2'b00);
        cycle(1'b1, 1'b0, want[1], 2'b00);
        cycle(1'b1, 1'b0, want[2], 2'b00);
        repeat (6) cycle(1'b0, 1'b0, 35'd0, 2'b11);
        tests++; if (got.size() != 4) begin fails++; $display("FAIL order_count got=%0d want=4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                tests++; if (got[i] !== want[i]) begin
                    fails++; $display("FAIL order_flit%0d got=%h want=%h", i, got[i], want[i]);
                end
            end
        end
        tests++; if (FLIT_CNT !== 16'd4) begin fails++; $display("FAIL order_cnt got=%h want=4", FLIT_CNT); end
    endtask

    task automatic test_stall();
        do_reset();
        cycle(1'b1, 1'b0, 35'h4_0000_0C00, 2'b00);
        cycle(1'b1, 1'b0, 35'h0_0000_0C01, 2'b00);
        cycle(1'b1, 1'b1, 35'h6_0000_0D00, 2'b01);
        for (int i = 0; i < 5; i++) begin
            tests++; if (OVALID !== 1'b1 || OVCH !== 1'b0 || ODATA !== 35'h0_0000_0C01) begin
                fails++; $display("FAIL stall_frozen%0d got=%b/%b/%h want=1/0/000000c01", i, OVALID, OVCH, ODATA);
            end
            cycle(1'b0, 1'b0, 35'd0, 2'b10);
        end
        tests++; if (got.size() != 1) begin fails++; $display("FAIL stall_sent got=%0d want=1", got.size()); end
        tests++; if (FLIT_CNT !== 16'd1) begin fails++; $display("FAIL stall_cnt got=%h want=1", FLIT_CNT); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 35'h6_0000_0E00 + 35'(i), 2'b00);
            tests++; if (IN_RDY[0] !== (i < 3)) begin
                fails++; $display("FAIL ovf_rdy%0d got=%b want=%b", i, IN_RDY[0], (i < 3));
            end
            tests++; if (OVF !== (i == 4)) begin
                fails++; $display("FAIL ovf_flag%0d got=%b want=%b", i, OVF, (i == 4));
            end
        end
        repeat (8) cycle(1'b0, 1'b0, 35'd0, 2'b11);
        tests++; if (got.size() != 4) begin fails++; $display("FAIL ovf_drain got=%0d want=4", got.size()); end
        tests++; if (got.size() == 4 && got[3] !== 35'h6_0000_0E03) begin
            fails++; $display("FAIL ovf_last got=%h want=600000e03", got[3]);
        end
        tests++; if (OVF !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b want=1", OVF); end
    endtask

    task automatic test_random();
        int shown = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        bad;
            logic [34:0] d;
            model_expect();
            bad = (IN_RDY !== e_rdy) || (OVALID !== e_valid) || (OVCH !== e_vch) ||
                  (ODATA !== e_data) || (OVF !== m_ovf) || (FLIT_CNT !== m_cnt);
            tests++;
            if (bad) begin
                fails++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random_cyc%0d got rdy=%b v=%b vc=%b d=%h ovf=%b cnt=%h want rdy=%b v=%b vc=%b d=%h ovf=%b cnt=%h",
                             i, IN_RDY, OVALID, OVCH, ODATA, OVF, FLIT_CNT,
                             e_rdy, e_valid, e_vch, e_data, m_ovf, m_cnt);
                end
            end
            d = {$urandom_range(0, 7), $urandom()};
            cycle(($urandom_range(0, 9) < 6), $urandom_range(0, 1), d, 2'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1'b1, 1'b1, 35'h4_0000_0F00, 2'b00);
        for (int i = 1; i < 5; i++) cycle(1'b1, 1'b1, 35'h0_0000_0F00 + 35'(i), 2'b00);
        cycle(1'b0, 1'b0, 35'd0, 2'b10);
        tests++; if (OVF !== 1'b1 || FLIT_CNT !== 16'd1) begin
            fails++; $display("FAIL mid_pre got=%b/%h want=1/0001", OVF, FLIT_CNT);
        end
        RST_ = 1'b0;
        #1;
        tests++; if (OVALID !== 1'b0) begin fails++; $display("FAIL mid_ovalid got=%b want=0", OVALID); end
        tests++; if (IN_RDY !== 2'b11) begin fails++; $display("FAIL mid_rdy got=%b want=11", IN_RDY); end
        tests++; if (FLIT_CNT !== 16'd0) begin fails++; $display("FAIL mid_cnt got=%h want=0", FLIT_CNT); end
        tests++; if (OVF !== 1'b0) begin fails++; $display("FAIL mid_ovf got=%b want=0", OVF); end
        @(negedge clk);
        RST_ = 1'b1;
        model_reset();
        got.delete();
        cycle(1'b1, 1'b0, 35'h4_0000_0A10, 2'b11);
        cycle(1'b1, 1'b0, 35'h2_0000_0A11, 2'b11);
        repeat (3) cycle(1'b0, 1'b0, 35'd0, 2'b11);
        tests++; if (got.size() != 2 || got[0] !== 35'h4_0000_0A10 || got[1] !== 35'h2_0000_0A11) begin
            fails++; $display("FAIL mid_newpkt got=%0d flits want=2 (400000a10, 200000a11)", got.size());
        end
        tests++; if (FLIT_CNT !== 16'd2) begin fails++; $display("FAIL mid_newcnt got=%h want=2", FLIT_CNT); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 65537; i++) begin
            cycle(1'b1, 1'b0, 35'h6_0000_0000 + 35'(i), 2'b11);
        end
        cycle(1'b0, 1'b0, 35'd0, 2'b11);
        tests++; if (FLIT_CNT !== 16'h0001) begin fails++; $display("FAIL wrap_cnt got=%h want=0001", FLIT_CNT); end
        tests++; if (OVF !== 1'b0) begin fails++; $display("FAIL wrap_ovf got=%b want=0", OVF); end
    endtask

    initial begin
        RST_     = 1'b0;
        IN_VALID = 1'b0;
        IN_VCH   = 1'b0;
        IN_DATA  = '0;
        IRDY     = 2'b00;
        model_reset();
        test_reset();
        test_single();
        test_order();
        test_stall();
        test_overflow();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
